// File: rtl/cntdn_timer_if.sv
// cntdn_timer_if: control, preset and display signals of the MM:SS countdown timer
interface cntdn_timer_if;
  logic       one_HZ_tick;
  logic       isSetting;
  logic       load;
  logic       start;
  logic       pause;
  logic [3:0] set_min_ten;
  logic [3:0] set_min_one;
  logic [3:0] set_sec_ten;
  logic [3:0] set_sec_one;
  logic [3:0] min_ten;
  logic [3:0] min_one;
  logic [3:0] sec_ten;
  logic [3:0] sec_one;
  logic       running;
  logic       done;
  logic       alarm;
  modport master (
    output one_HZ_tick, isSetting, load, start, pause,
    output set_min_ten, set_min_one, set_sec_ten, set_sec_one,
    input  min_ten, min_one, sec_ten, sec_one, running, done, alarm
  );
  modport slave (
    input  one_HZ_tick, isSetting, load, start, pause,
    input  set_min_ten, set_min_one, set_sec_ten, set_sec_one,
    output min_ten, min_one, sec_ten, sec_one, running, done, alarm
  );
endinterface

// File: rtl/cntdn_timer.sv
// cntdn_timer: BCD MM:SS countdown timer with clamped preset load, pause/resume and expiry alarm
module cntdn_timer #(
  parameter int MIN_TEN_MAX = 9,
  parameter bit AUTO_CLEAR  = 1'b0,
  parameter int ALARM_TICKS = 10
) (
  input logic         clk,
  input logic         CLR_n,
  cntdn_timer_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
  state_t     state, state_n;
  logic [3:0] min_ten, min_one, sec_ten, sec_one;
  logic [3:0] min_ten_n, min_one_n, sec_ten_n, sec_one_n;
  logic [3:0] alarm_cnt, alarm_cnt_n;
  logic       running, done, alarm, done_n;
  logic       is_zero, is_one, dec, alarm_end;
  logic       b0, b1, b2;
  assign is_zero   = {min_ten, min_one, sec_ten, sec_one} == 16'h0000;
  assign is_one    = {min_ten, min_one, sec_ten, sec_one} == 16'h0001;
  assign dec       = state == RUN && !bus.isSetting && !bus.pause && bus.one_HZ_tick;
  assign alarm_end = AUTO_CLEAR && bus.one_HZ_tick && alarm_cnt == 4'(ALARM_TICKS - 1);
  // state, digits and flags register; flags are registered so they align with the digits
  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      state     <= IDLE;
      min_ten   <= 4'd0;
      min_one   <= 4'd0;
      sec_ten   <= 4'd0;
      sec_one   <= 4'd0;
      alarm_cnt <= 4'd0;
      running   <= 1'b0;
      done      <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state     <= state_n;
      min_ten   <= min_ten_n;
      min_one   <= min_one_n;
      sec_ten   <= sec_ten_n;
      sec_one   <= sec_one_n;
      alarm_cnt <= alarm_cnt_n;
      running   <= state_n == RUN;
      done      <= done_n;
      alarm     <= state_n == DONE;
    end
  end
  // next state: setting overrides everything, pause only matters while running
  always_comb begin
    state_n = state;
    if (bus.isSetting) state_n = IDLE;
    else
      case (state)
        IDLE:    state_n = (bus.start && !is_zero) ? RUN : IDLE;
        RUN:     state_n = bus.pause ? PAUSE : (bus.one_HZ_tick && is_one) ? DONE : RUN;
        PAUSE:   state_n = (bus.start && !is_zero) ? RUN : PAUSE;
        DONE:    state_n = (bus.start || alarm_end) ? IDLE : DONE;
        default: state_n = IDLE;
      endcase
  end
  // next digits: clamped preset load or one-second borrow-chain decrement
  always_comb begin
    b0 = sec_one == 4'd0;
    b1 = b0 && sec_ten == 4'd0;
    b2 = b1 && min_one == 4'd0;
    {min_ten_n, min_one_n, sec_ten_n, sec_one_n} = {min_ten, min_one, sec_ten, sec_one};
    if (bus.isSetting && bus.load) begin
      min_ten_n = (bus.set_min_ten > 4'(MIN_TEN_MAX)) ? 4'(MIN_TEN_MAX) : bus.set_min_ten;
      min_one_n = (bus.set_min_one > 4'd9) ? 4'd9 : bus.set_min_one;
      sec_ten_n = (bus.set_sec_ten > 4'd5) ? 4'd5 : bus.set_sec_ten;
      sec_one_n = (bus.set_sec_one > 4'd9) ? 4'd9 : bus.set_sec_one;
    end else if (dec) begin
      sec_one_n = b0 ? 4'd9 : sec_one - 4'd1;
      sec_ten_n = !b0 ? sec_ten : b1 ? 4'd5 : sec_ten - 4'd1;
      min_one_n = !b1 ? min_one : b2 ? 4'd9 : min_one - 4'd1;
      min_ten_n = b2 ? min_ten - 4'd1 : min_ten;
    end
    done_n      = dec && is_one;
    alarm_cnt_n = (AUTO_CLEAR && state == DONE && state_n == DONE) ? alarm_cnt + {3'd0, bus.one_HZ_tick} : 4'd0;
  end
  assign bus.min_ten = min_ten;
  assign bus.min_one = min_one;
  assign bus.sec_ten = sec_ten;
  assign bus.sec_one = sec_one;
  assign bus.running = running;
  assign bus.done    = done;
  assign bus.alarm   = alarm;
endmodule
